// File: rtl/xcorr_peak_finder.sv
// Serial peak search over six snapshotted cross-correlation vectors.
// Reports, per microphone pair, the signed lag of the maximum and its value.
module xcorr_peak_finder #(
    parameter int MAX_SAMPLES_DELAY = 11,
    parameter int NUM_BITS_XCORR    = 31,
    parameter int NUM_XCORRS        = 6,
    parameter int LAG_BITS          = $clog2(MAX_SAMPLES_DELAY + 1) + 1
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     start,
    input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0]  xCorrIn0,
    input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0]  xCorrIn1,
    input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0]  xCorrIn2,
    input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0]  xCorrIn3,
    input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0]  xCorrIn4,
    input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0]  xCorrIn5,
    output logic                                                     busy,
    output logic                                                     delayValid,
    output logic signed [NUM_XCORRS-1:0][LAG_BITS-1:0]               delayOut,
    output logic signed [NUM_XCORRS-1:0][NUM_BITS_XCORR-1:0]         peakOut
);

    localparam int L     = 2 * MAX_SAMPLES_DELAY + 1;
    localparam int IDX_W = $clog2(L);

    typedef logic [L-1:0][NUM_BITS_XCORR-1:0] vec_t;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             delay_valid_q, delay_valid_d;
    logic             load_en, scan_en, done_en;
    vec_t             in_vec [NUM_XCORRS];

    assign in_vec[0] = xCorrIn0;
    assign in_vec[1] = xCorrIn1;
    assign in_vec[2] = xCorrIn2;
    assign in_vec[3] = xCorrIn3;
    assign in_vec[4] = xCorrIn4;
    assign in_vec[5] = xCorrIn5;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (idx_q == IDX_W'(L - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy          = (state_q != IDLE);
        load_en       = (state_q == IDLE) && start;
        scan_en       = (state_q == SCAN);
        done_en       = (state_q == DONE);
        delay_valid_d = done_en;
        idx_d         = idx_q;
        if (load_en) begin
            idx_d = IDX_W'(1);
        end else if (scan_en && (idx_q != IDX_W'(L - 1))) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q         <= '0;
            delay_valid_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            delay_valid_q <= delay_valid_d;
        end
    end

    assign delayValid = delay_valid_q;

    // One independent tracker per microphone pair, all stepping on the shared idx.
    for (genvar gi = 0; gi < NUM_XCORRS; gi++) begin : g_pair
        vec_t                              snap_q, snap_d;
        logic signed [NUM_BITS_XCORR-1:0]  best_q, best_d;
        logic [IDX_W-1:0]                  best_idx_q, best_idx_d;
        logic signed [LAG_BITS-1:0]        delay_q, delay_d;
        logic signed [NUM_BITS_XCORR-1:0]  peak_q, peak_d;
        logic signed [NUM_BITS_XCORR-1:0]  cand;
        logic signed [LAG_BITS-1:0]        lag_w;

        assign cand  = $signed(snap_q[idx_q]);
        assign lag_w = LAG_BITS'(int'({1'b0, best_idx_q}) - MAX_SAMPLES_DELAY);

        always_comb begin
            snap_d     = snap_q;
            best_d     = best_q;
            best_idx_d = best_idx_q;
            delay_d    = delay_q;
            peak_d     = peak_q;
            if (load_en) begin
                snap_d     = in_vec[gi];
                best_d     = $signed(in_vec[gi][0]);
                best_idx_d = '0;
            end else if (scan_en) begin
                // Strict compare keeps the lowest index among equal maxima.
                if (cand > best_q) begin
                    best_d     = cand;
                    best_idx_d = idx_q;
                end
            end else if (done_en) begin
                delay_d = lag_w;
                peak_d  = best_q;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                snap_q     <= '0;
                best_q     <= '0;
                best_idx_q <= '0;
                delay_q    <= '0;
                peak_q     <= '0;
            end else begin
                snap_q     <= snap_d;
                best_q     <= best_d;
                best_idx_q <= best_idx_d;
                delay_q    <= delay_d;
                peak_q     <= peak_d;
            end
        end

        assign delayOut[gi] = delay_q;
        assign peakOut[gi]  = peak_q;
    end

endmodule

// File: tb/tb_xcorr_peak_finder.sv
// Directed + randomized bench for xcorr_peak_finder against a max-then-first-index model.
module tb_xcorr_peak_finder;

    localparam int MSD = 11;
    localparam int W   = 31;
    localparam int L   = 2 * MSD + 1;
    localparam int NP  = 6;
    localparam int LB  = 5;

    typedef logic [L-1:0][W-1:0] vec_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    vec_t                        x [NP];
    logic                        busy;
    logic                        delay_valid;
    logic signed [NP-1:0][LB-1:0] delay_out;
    logic signed [NP-1:0][W-1:0]  peak_out;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint exp_lag [4][NP];
    longint exp_pk  [4][NP];

    always #5 clk = ~clk;

    xcorr_peak_finder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .xCorrIn0   (x[0]),
        .xCorrIn1   (x[1]),
        .xCorrIn2   (x[2]),
        .xCorrIn3   (x[3]),
        .xCorrIn4   (x[4]),
        .xCorrIn5   (x[5]),
        .busy       (busy),
        .delayValid (delay_valid),
        .delayOut   (delay_out),
        .peakOut    (peak_out)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: find the maximum value, then the first index holding it.
    function automatic void ref_peak(input vec_t v, output longint lag, output longint pk);
        longint m;
        m = $signed(v[0]);
        for (int k = 1; k < L; k++) if ($signed(v[k]) > m) m = $signed(v[k]);
        pk  = m;
        lag = 0;
        for (int k = 0; k < L; k++) begin
            if ($signed(v[k]) == m) begin
                lag = k - MSD;
                break;
            end
        end
    endfunction

    task automatic compute_exp(input int s);
        for (int p = 0; p < NP; p++) ref_peak(x[p], exp_lag[s][p], exp_pk[s][p]);
    endtask

    task automatic check_outputs(input string tag, input int s);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("%s_delay%0d", tag, p), longint'($signed(delay_out[p])), exp_lag[s][p]);
            check($sformatf("%s_peak%0d", tag, p), longint'($signed(peak_out[p])), exp_pk[s][p]);
        end
    endtask

    task automatic clear_vectors();
        for (int p = 0; p < NP; p++) x[p] = '0;
    endtask

    task automatic rand_vectors(input int mode);
        logic [31:0] r;
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < L; k++) begin
                r = $urandom;
                if (mode == 0) x[p][k] = r[W-1:0];
                else           x[p][k] = W'(int'($urandom_range(0, 7)) - 4);
            end
        end
    endtask

    // Pulse start, expect delayValid 23 cycles after the start edge, then check results.
    task automatic run_scan(input string tag);
        int cyc;
        compute_exp(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_hi"}, longint'(busy), 1);
        cyc = 0;
        while (!delay_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 23);
        check({tag, "_busy_lo"}, longint'(busy), 0);
        check_outputs(tag, 0);
        @(negedge clk);
        check({tag, "_valid_1cyc"}, longint'(delay_valid), 0);
        $display("scan %s: latency %0d delay0 %0d peak0 %0d", tag, cyc,
                 $signed(delay_out[0]), $signed(peak_out[0]));
    endtask

    initial begin
        int nv;
        int first_v;
        int vtimes [3];

        rst   = 1'b1;
        start = 1'b0;
        clear_vectors();
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_valid", longint'(delay_valid), 0);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("rst_delay%0d", p), longint'($signed(delay_out[p])), 0);
            check($sformatf("rst_peak%0d", p), longint'($signed(peak_out[p])), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset checked");

        // Centred peak
        x[0][11] = W'(1000);
        run_scan("centred");
        check("centred_c_delay0", longint'($signed(delay_out[0])), 0);
        check("centred_c_peak0", longint'($signed(peak_out[0])), 1000);
        check("centred_c_delay1", longint'($signed(delay_out[1])), -11);

        // Extremes, tie and negatives
        clear_vectors();
        x[1][0]  = W'(500);
        x[2][22] = W'(500);
        x[3][5]  = W'(700);
        x[3][15] = W'(700);
        for (int k = 0; k < L; k++) begin
            x[4][k] = W'(-100);
            x[5][k] = W'(k);
        end
        x[4][17] = W'(-3);
        run_scan("extremes");
        check("ext_c_delay1", longint'($signed(delay_out[1])), -11);
        check("ext_c_delay2", longint'($signed(delay_out[2])), 11);
        check("ext_c_delay3", longint'($signed(delay_out[3])), -6);
        check("ext_c_delay4", longint'($signed(delay_out[4])), 6);
        check("ext_c_peak4", longint'($signed(peak_out[4])), -3);
        check("ext_c_delay5", longint'($signed(delay_out[5])), 11);
        check("ext_c_peak5", longint'($signed(peak_out[5])), 22);

        // Random vectors: wide range and tie-heavy small range
        for (int t = 0; t < 4; t++) begin
            rand_vectors(t % 2);
            run_scan($sformatf("rand%0d", t));
        end

        // Snapshot and busy: inputs change mid-scan, second start ignored
        rand_vectors(0);
        compute_exp(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nv = 0;
        first_v = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 2) for (int p = 0; p < NP; p++) x[p][20] = W'(32'h3FFF_FFFF);
            if (cyc == 4) start = 1'b1;
            if (cyc == 5) start = 1'b0;
            if (delay_valid) begin
                nv++;
                if (first_v < 0) first_v = cyc;
            end
        end
        check("snap_valid_count", nv, 1);
        check("snap_valid_cycle", first_v, 23);
        check_outputs("snap", 0);
        $display("snapshot: valids %0d at cycle %0d", nv, first_v);

        // Back-to-back with start held high for 60 cycles
        rand_vectors(0);
        compute_exp(0);
        start = 1'b1;
        @(negedge clk);
        nv = 0;
        for (int cyc = 1; cyc <= 90; cyc++) begin
            @(negedge clk);
            if (delay_valid) begin
                if (nv < 3) begin
                    vtimes[nv] = cyc;
                    check_outputs($sformatf("b2b%0d", nv), nv);
                end
                nv++;
            end
            if (cyc == 10) begin rand_vectors(1); compute_exp(1); end
            if (cyc == 30) begin rand_vectors(0); compute_exp(2); end
            if (cyc == 59) start = 1'b0;
        end
        check("b2b_count", nv, 3);
        check("b2b_t0", vtimes[0], 23);
        check("b2b_t1", vtimes[1], 47);
        check("b2b_t2", vtimes[2], 71);
        $display("back-to-back: %0d valids at %0d %0d %0d", nv, vtimes[0], vtimes[1], vtimes[2]);

        // Reset mid-scan
        rand_vectors(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nv = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 9) begin
                rst = 1'b1;
                #1;
                check("mrst_busy", longint'(busy), 0);
                check("mrst_valid", longint'(delay_valid), 0);
                for (int p = 0; p < NP; p++) begin
                    check($sformatf("mrst_delay%0d", p), longint'($signed(delay_out[p])), 0);
                    check($sformatf("mrst_peak%0d", p), longint'($signed(peak_out[p])), 0);
                end
            end
            if (cyc == 11) rst = 1'b0;
            if (delay_valid) nv++;
        end
        check("mrst_no_valid", nv, 0);
        $display("mid-scan reset: valids after abort %0d", nv);
        rand_vectors(1);
        run_scan("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
